// File: rtl/binary_game_input_ctrl.sv
// Player input front end for binary_game: synchronises and debounces four push-buttons,
// issues one arbitrated 1-cycle pulse per press and captures the switches with Select.
module binary_game_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SW_WIDTH        = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                btnSelect,
  input  logic                btnQuit,
  input  logic                btnLeft,
  input  logic                btnRight,
  input  logic [SW_WIDTH-1:0] sw,
  output logic                Select,
  output logic                Quit,
  output logic                selectLeft,
  output logic                selectRight,
  output logic [SW_WIDTH-1:0] userNumber
);

  localparam int NBTN  = 4;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_PRESS = 3'd1,
    FIRE    = 3'd2,
    HELD    = 3'd3,
    W_REL   = 3'd4
  } btnState_e;

  // Bit order: 0 = Quit, 1 = Select, 2 = Left, 3 = Right (also the priority order).
  logic [NBTN-1:0]     btnRaw_s;
  logic [NBTN-1:0]     btnMeta_r;
  logic [NBTN-1:0]     btnSync_r;
  logic [SW_WIDTH-1:0] swMeta_r;
  logic [SW_WIDTH-1:0] swSync_r;
  btnState_e           state_r     [NBTN];
  btnState_e           stateNext_s [NBTN];
  logic [CNT_W-1:0]    cnt_r       [NBTN];
  logic [CNT_W-1:0]    cntNext_s   [NBTN];
  logic [NBTN-1:0]     fire_s;
  logic [NBTN-1:0]     win_s;

  assign btnRaw_s = {btnRight, btnLeft, btnSelect, btnQuit};

  // Two-flop synchronisers for buttons and switches.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btnMeta_r <= {NBTN{1'b0}};
      btnSync_r <= {NBTN{1'b0}};
      swMeta_r  <= {SW_WIDTH{1'b0}};
      swSync_r  <= {SW_WIDTH{1'b0}};
    end else begin
      btnMeta_r <= btnRaw_s;
      btnSync_r <= btnMeta_r;
      swMeta_r  <= sw;
      swSync_r  <= swMeta_r;
    end
  end

  // Debounce FSM state and counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NBTN; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state_r[i] <= stateNext_s[i];
        cnt_r[i]   <= cntNext_s[i];
      end
    end
  end

  // Debounce FSM next state; fire_s marks the edge on which a press is accepted.
  always_comb begin
    fire_s = {NBTN{1'b0}};
    for (int i = 0; i < NBTN; i++) begin
      stateNext_s[i] = state_r[i];
      cntNext_s[i]   = cnt_r[i];
      case (state_r[i])
        IDLE: begin
          if (btnSync_r[i]) begin
            stateNext_s[i] = W_PRESS;
            cntNext_s[i]   = CNT_ONE;
          end else begin
            cntNext_s[i] = CNT_ZERO;
          end
        end
        W_PRESS: begin
          if (!btnSync_r[i]) begin
            stateNext_s[i] = IDLE;
            cntNext_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == CNT_LAST) begin
            stateNext_s[i] = FIRE;
            cntNext_s[i]   = CNT_ZERO;
            fire_s[i]      = 1'b1;
          end else begin
            cntNext_s[i] = cnt_r[i] + CNT_ONE;
          end
        end
        FIRE: begin
          stateNext_s[i] = HELD;
          cntNext_s[i]   = CNT_ZERO;
        end
        HELD: begin
          if (!btnSync_r[i]) begin
            stateNext_s[i] = W_REL;
            cntNext_s[i]   = CNT_ONE;
          end else begin
            cntNext_s[i] = CNT_ZERO;
          end
        end
        W_REL: begin
          if (btnSync_r[i]) begin
            stateNext_s[i] = HELD;
            cntNext_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == CNT_LAST) begin
            stateNext_s[i] = IDLE;
            cntNext_s[i]   = CNT_ZERO;
          end else begin
            cntNext_s[i] = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          stateNext_s[i] = IDLE;
          cntNext_s[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Fixed-priority arbitration; losing presses are dropped.
  always_comb begin
    win_s    = {NBTN{1'b0}};
    win_s[0] = fire_s[0];
    win_s[1] = fire_s[1] & ~fire_s[0];
    win_s[2] = fire_s[2] & ~fire_s[1] & ~fire_s[0];
    win_s[3] = fire_s[3] & ~fire_s[2] & ~fire_s[1] & ~fire_s[0];
  end

  // Registered pulses; the switch value is captured on the edge that raises Select.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Quit        <= 1'b0;
      Select      <= 1'b0;
      selectLeft  <= 1'b0;
      selectRight <= 1'b0;
      userNumber  <= {SW_WIDTH{1'b0}};
    end else begin
      Quit        <= win_s[0];
      Select      <= win_s[1];
      selectLeft  <= win_s[2];
      selectRight <= win_s[3];
      if (win_s[1]) begin
        userNumber <= swSync_r;
      end else begin
        userNumber <= userNumber;
      end
    end
  end

endmodule
